// File: rtl/div113_seq_ctrl.sv
// div113_seq_ctrl: iterative divide-by-constant controller retiring STEP dividend bits per cycle.
// Optional DIV113_SELF_CHECK_EN: checks out_quot*D+out_rem against the dividend and sets sticky err.
module div113_seq_ctrl #(
    parameter int DW   = 24,
    parameter int D    = 113,
    parameter int RW   = 7,
    parameter int STEP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_dividend,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_quot,
    output logic [RW-1:0] out_rem,
    output logic          busy,
    output logic          err
);
    localparam int PW = RW + STEP;
    localparam int NI = DW / STEP;
    localparam int CW = $clog2(NI + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state;
    logic [DW-1:0]   sr;
    logic [DW-1:0]   quot;
    logic [RW-1:0]   rem;
    logic [RW-1:0]   rem_n;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   partial;
    logic [STEP-1:0] digit;
    logic [DW-1:0]   quot_n;
    // Largest multiple of D not exceeding the partial remainder, via parallel constant compares
    always_comb begin
        partial = {rem, sr[DW-1 -: STEP]};
        digit = '0;
        for (int k = 1; k < 2**STEP; k++)
            if (partial >= PW'(k * D)) digit = STEP'(k);
        rem_n = RW'(partial - PW'(digit) * PW'(D));
        quot_n = {quot[DW-STEP-1:0], digit};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
            busy      <= 1'b0;
            sr        <= '0;
            quot      <= '0;
            rem       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        sr       <= in_dividend;
                        rem      <= '0;
                        quot     <= '0;
                        cnt      <= CW'(NI - 1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sr   <= sr << STEP;
                    rem  <= rem_n;
                    quot <= quot_n;
                    if (cnt == '0) begin
                        out_quot  <= quot_n;
                        out_rem   <= rem_n;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DIV113_SELF_CHECK_EN
    localparam int XW = DW + RW;
    logic [DW-1:0] orig;
    logic          chk;
    // chk marks the first DONE cycle, when out_quot/out_rem have just been loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig <= '0;
            chk  <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid && in_ready) orig <= in_dividend;
            chk <= state == RUN && cnt == '0;
            if (chk && XW'(out_quot) * XW'(D) + XW'(out_rem) != XW'(orig)) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_div113_seq_ctrl.sv
// tb_div113_seq_ctrl: scoreboard bench for div113_seq_ctrl with directed and random dividends.
module tb_div113_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_dividend = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_quot;
    logic [6:0]  out_rem;
    logic        busy;
    logic        err;

    typedef struct {
        logic [23:0] q;
        logic [6:0]  r;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int rises = 0;
    logic ov_d = 1'b0;
    logic rand_rdy = 1'b0;

    div113_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && !ov_d) begin
            rises++;
            chk("latency", cyc - hs_cyc, 13);
        end
        ov_d <= rst_n && out_valid;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 1, 0);
            else begin
                e = sb.pop_front();
                chk("quot", out_quot, e.q);
                chk("rem", out_rem, e.r);
                chk("err", err, 0);
            end
        end
    end

    always @(posedge clk) if (rand_rdy) #1 out_ready = 1'($urandom_range(0, 1));

    task automatic send(input logic [23:0] a, input logic [23:0] q, input logic [6:0] r, input bit track);
        int n = 0;
        if (track) sb.push_back('{q: q, r: r});
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_dividend = a;
        do begin @(negedge clk); n++; end while (!in_ready && n < 100);
        if (!in_ready) chk("accept_timeout", 1, 0);
        hs_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin @(negedge clk); n++; end
        chk("drain_timeout", sb.size() != 0 || out_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] q0;
        logic [6:0]  r0;
        bit          stable;
        int          n0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quot", out_quot, 0);
        chk("rst_rem", out_rem, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);

        send(24'd0, 24'd0, 7'd0, 1);           wait_idle();
        send(24'd113, 24'd1, 7'd0, 1);         wait_idle();
        send(24'd112, 24'd0, 7'd112, 1);       wait_idle();
        send(24'd1000, 24'd8, 7'd96, 1);       wait_idle();
        send(24'hFFFFFF, 24'h243F6, 7'd105, 1); wait_idle();
        send(24'd226, 24'd2, 7'd0, 1);         wait_idle();

        // Backpressure: hold the result for 20 cycles
        out_ready = 1'b0;
        send(24'd1000, 24'd8, 7'd96, 1);
        n0 = 0;
        while (!out_valid && n0 < 100) begin @(negedge clk); n0++; end
        chk("bp_valid", out_valid, 1);
        q0 = out_quot;
        r0 = out_rem;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            stable &= out_valid && out_quot == q0 && out_rem == r0 && !in_ready;
        end
        chk("bp_hold", stable, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_valid_drop", out_valid, 0);
        wait_idle();

        // Reset in the middle of an iteration
        send(24'd5000, 24'd44, 7'd28, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_quot", out_quot, 0);
        chk("mid_rst_rem", out_rem, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        n0 = rises;
        send(24'd5000, 24'd44, 7'd28, 1);
        wait_idle();
        repeat (20) @(negedge clk);
        chk("single_out_pulse", rises - n0, 1);

        // Random dividends with random source gaps and consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [23:0] a;
            a = 24'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(a, 24'(a / 113), 7'(a % 113), 1);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle();
        chk("final_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div113_seq_ctrl.md
Name: div113_seq_ctrl

Overview:
Iterative constant-divisor divider controller. It divides an unsigned DW-bit dividend by constant D, retiring STEP dividend bits per cycle through a remainder/quotient-digit step stage. The dividend is shifted in MSB first with a carried remainder. The block sits between the operand source and the quotient consumer, with valid/ready handshakes on both sides. It sequences the step datapath and owns all operand, remainder and quotient state.

Parameters:
DW, 24, dividend and quotient width; must be a multiple of STEP
D, 113, constant divisor; 2 <= D < 2^RW
RW, 7, remainder width, ceil(log2(D))
STEP, 2, dividend bits consumed per iteration

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  dividend offered
in_ready  out  1  block accepts dividend
in_dividend  in  DW  unsigned dividend
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_quot  out  DW  quotient floor(dividend/D)
out_rem  out  RW  remainder dividend mod D
busy  out  1  iteration in progress
err  out  1  sticky self-check failure (see Optional Feature)

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in IDLE. out_valid=0, out_quot=0, out_rem=0, busy=0, err=0. FSM=IDLE, iteration counter=0.
- Reset is asynchronous and active-low. Assertion at any point, including mid-RUN or in DONE, aborts the operation and discards operand and result. No output pulse follows reset.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch in_dividend into the shift register;
  - clear rem and quot;
  - counter=DW/STEP-1;
  - go to RUN.
- RUN: in_ready=0, busy=1. Each cycle:
  - partial = {rem, top STEP bits of shift register}, RW+STEP bits;
  - digit = largest k in 0..2^STEP-1 with k*D <= partial, by parallel compares against k*D constants;
  - rem <= partial - digit*D;
  - quot <= {quot[DW-STEP-1:0], digit};
  - shift register shifts left by STEP.
- RUN exit: at counter==0, go to DONE; otherwise decrement the counter.
- Latency: in-handshake cycle to out_valid rising is DW/STEP+1 cycles, 13 at defaults. Fixed and data-independent.
- DONE: out_valid=1 with out_quot/out_rem held stable. On out_valid&out_ready go to IDLE; out_valid drops next cycle.
- Back-to-back: no input is accepted in the same cycle as the output handshake. in_ready rises the cycle after.
- Invariants:
  - rem < D after every step;
  - digit never exceeds 2^STEP-1;
  - quot upper bits beyond ceil(log2(2^DW/D)) are always 0.
- out_quot/out_rem are registered. Their value outside DONE is the last result (or reset 0), and consumers ignore it.
- in_valid while not IDLE is ignored; the source holds it.

Optional Feature:
Macro: DIV113_SELF_CHECK_EN.
- Defined:
  - the original dividend is retained in a DW-bit register;
  - on entering DONE, the block compares out_quot*D+out_rem against it;
  - mismatch sets err, which stays sticky until rst_n;
  - check logic adds one register stage but does not change latency or handshake timing.
- Undefined: err tied to 0, no extra register, no multiplier.

Test Plan:
- dividend 0 -> out_quot=0, out_rem=0 after 13 cycles; err=0.
- dividend 113 -> quot=1, rem=0; dividend 112 -> quot=0, rem=112; dividend 1000 -> quot=8, rem=96.
- dividend 0xFFFFFF (16777215) -> quot=148470 (0x243F6), rem=105; checks MSB-chunk carry and max value.
- Backpressure: hold out_ready=0 for 20 cycles after DONE -> out_valid stays 1, outputs stable, in_ready=0. Release -> one transfer, in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 at step 5 of dividend 5000 -> all outputs at reset values immediately. Next operation 5000 -> quot=44, rem=28, exactly one out_valid assertion.
- Random 10k dividends with random in_valid/out_ready gaps -> every result matches the floor/mod model. err stays 0 with DIV113_SELF_CHECK_EN; a forced rem corruption sets err.
